// File: rtl/lc3_operate_ctrl.sv
// -----------------------------------------------------------------------------
// lc3_operate_ctrl
//
// Multi-cycle sequencer for the LC-3 operate instructions ADD, AND and NOT.
// An instruction is accepted over a valid/ready handshake. It is then walked
// through register-file read, ALU operand setup, result capture, and finally
// writeback with a condition-code update. The controller sits between
// fetch/decode and the shared ALU / register file. It drives the ALU's A/B/ALUK
// inputs and samples the ALU result combinationally.
//
// Sequence (one state per cycle):
//   IDLE -> DECODE -> READ -> EXEC -> WB -> IDLE
//   Handshake in cycle 0, done pulse in cycle 4, next accept in cycle 5.
//
// Ports
//   clk, rst_n                 clock, synchronous active-low reset
//   instr_valid / instr_ready  instruction handshake
//   instr                      16-bit instruction word
//   sr1_sel, sr2_sel           register-file read addresses
//   rf_sr1_data, rf_sr2_data   read data, valid the cycle after the address
//   alu_a, alu_b, aluk         registered ALU operands / operation
//   alu_out                    ALU result (combinational)
//   gate_alu                   ALU bus driver enable (EXEC cycle)
//   ld_reg, dr_sel, wb_data    register-file writeback (WB cycle)
//   ld_cc, nzp                 condition-code load pulse and register
//   done                       operation retired (WB cycle)
//   illegal                    non-operate opcode rejected (DECODE cycle)
// -----------------------------------------------------------------------------
module lc3_operate_ctrl #(
  parameter int unsigned DATA_W    = 16,
  parameter logic [2:0]  NZP_RESET = 3'b010
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [15:0]       instr,
  output logic [2:0]        sr1_sel,
  output logic [2:0]        sr2_sel,
  input  logic [DATA_W-1:0] rf_sr1_data,
  input  logic [DATA_W-1:0] rf_sr2_data,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [1:0]        aluk,
  input  logic [DATA_W-1:0] alu_out,
  output logic              gate_alu,
  output logic              ld_reg,
  output logic [2:0]        dr_sel,
  output logic [DATA_W-1:0] wb_data,
  output logic              ld_cc,
  output logic [2:0]        nzp,
  output logic              done,
  output logic              illegal
);

  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_NOT = 4'b1001;

  typedef enum logic [1:0] {
    ALUK_ADD   = 2'd0,
    ALUK_AND   = 2'd1,
    ALUK_NOT   = 2'd2,
    ALUK_PASSA = 2'd3
  } aluk_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_READ,
    S_EXEC,
    S_WB
  } state_t;

  state_t            state_q;
  logic [15:0]       instr_q;
  logic              instr_ready_q;
  logic [2:0]        sr1_sel_q, sr2_sel_q, dr_sel_q;
  logic [DATA_W-1:0] alu_a_q, alu_b_q, wb_data_q;
  aluk_t             aluk_q;
  logic              gate_alu_q, ld_reg_q, ld_cc_q, done_q, illegal_q;
  logic [2:0]        nzp_q;

  logic [DATA_W-1:0] alu_b_d;
  aluk_t             aluk_d;
  logic [2:0]        nzp_d;

  function automatic logic is_operate(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_AND) || (op == OP_NOT);
  endfunction

  // Operand B and ALU op are derived from the latched instruction. The
  // immediate form takes precedence over SR2 whenever bit 5 is set.
  always_comb begin
    alu_b_d = instr_q[5] ? {{(DATA_W-5){instr_q[4]}}, instr_q[4:0]} : rf_sr2_data;
    unique case (instr_q[15:12])
      OP_AND:  aluk_d = ALUK_AND;
      OP_NOT:  aluk_d = ALUK_NOT;
      default: aluk_d = ALUK_ADD;
    endcase
  end

  // The condition codes come from the captured result that is being written back.
  always_comb begin
    if (wb_data_q[DATA_W-1])   nzp_d = 3'b100;
    else if (wb_data_q == '0)  nzp_d = 3'b010;
    else                       nzp_d = 3'b001;
  end

  // NOTE: all state here is sequential, so every assignment in this block is
  // non-blocking. Reset is synchronous: rst_n is only looked at on a clock edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      instr_q       <= '0;
      instr_ready_q <= 1'b1;
      sr1_sel_q     <= '0;
      sr2_sel_q     <= '0;
      dr_sel_q      <= '0;
      alu_a_q       <= '0;
      alu_b_q       <= '0;
      aluk_q        <= ALUK_ADD;
      wb_data_q     <= '0;
      gate_alu_q    <= 1'b0;
      ld_reg_q      <= 1'b0;
      ld_cc_q       <= 1'b0;
      done_q        <= 1'b0;
      illegal_q     <= 1'b0;
      nzp_q         <= NZP_RESET;
    end else begin
      // NOTE: the single-cycle strobes default low every cycle; each state
      // raises the strobe that belongs to the *next* state so the registered
      // output is high for exactly that state's cycle.
      gate_alu_q <= 1'b0;
      ld_reg_q   <= 1'b0;
      ld_cc_q    <= 1'b0;
      done_q     <= 1'b0;
      illegal_q  <= 1'b0;

      unique case (state_q)
        S_IDLE: begin
          if (instr_valid && instr_ready_q) begin
            instr_q       <= instr;
            sr1_sel_q     <= instr[8:6];
            sr2_sel_q     <= instr[2:0];
            dr_sel_q      <= instr[11:9];
            illegal_q     <= !is_operate(instr[15:12]);
            instr_ready_q <= 1'b0;
            state_q       <= S_DECODE;
          end
        end

        S_DECODE: begin
          if (is_operate(instr_q[15:12])) begin
            state_q <= S_READ;
          end else begin
            // Rejected: nothing further is driven, ready again next cycle.
            instr_ready_q <= 1'b1;
            state_q       <= S_IDLE;
          end
        end

        S_READ: begin
          alu_a_q    <= rf_sr1_data;
          alu_b_q    <= alu_b_d;
          aluk_q     <= aluk_d;
          gate_alu_q <= 1'b1;
          state_q    <= S_EXEC;
        end

        S_EXEC: begin
          wb_data_q <= alu_out;
          ld_reg_q  <= 1'b1;
          ld_cc_q   <= 1'b1;
          done_q    <= 1'b1;
          state_q   <= S_WB;
        end

        S_WB: begin
          nzp_q         <= nzp_d;
          instr_ready_q <= 1'b1;
          state_q       <= S_IDLE;
        end

        default: begin
          instr_ready_q <= 1'b1;
          state_q       <= S_IDLE;
        end
      endcase
    end
  end

  assign instr_ready = instr_ready_q;
  assign sr1_sel     = sr1_sel_q;
  assign sr2_sel     = sr2_sel_q;
  assign dr_sel      = dr_sel_q;
  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign aluk        = aluk_q;
  assign wb_data     = wb_data_q;
  assign gate_alu    = gate_alu_q;
  assign ld_reg      = ld_reg_q;
  assign ld_cc       = ld_cc_q;
  assign done        = done_q;
  assign illegal     = illegal_q;
  assign nzp         = nzp_q;

endmodule

// File: tb/tb_lc3_operate_ctrl.sv
// -----------------------------------------------------------------------------
// tb_lc3_operate_ctrl
//
// Testbench for lc3_operate_ctrl. It provides a small environment consisting of
// an 8-entry register file with synchronous read and writeback on ld_reg, and a
// combinational ALU. Expected values come from an instruction-level reference
// model that tracks architectural registers and condition codes.
// -----------------------------------------------------------------------------
module tb_lc3_operate_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instr_valid = 1'b0;
  logic [15:0] instr = '0;
  logic        instr_ready;
  logic [2:0]  sr1_sel, sr2_sel, dr_sel;
  logic [15:0] rf_sr1_data, rf_sr2_data;
  logic [15:0] alu_a, alu_b, alu_out, wb_data;
  logic [1:0]  aluk;
  logic        gate_alu, ld_reg, ld_cc, done, illegal;
  logic [2:0]  nzp;

  int vectors = 0;
  int miscompares = 0;

  // Environment register file and preload path.
  logic [15:0] regs [8];
  logic [15:0] preload_vals [8];
  logic        preload_en = 1'b0;

  // Reference model state.
  logic [15:0] ref_regs [8];
  logic [2:0]  ref_nzp;

  always #5 clk = ~clk;

  lc3_operate_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .sr1_sel     (sr1_sel),
    .sr2_sel     (sr2_sel),
    .rf_sr1_data (rf_sr1_data),
    .rf_sr2_data (rf_sr2_data),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .aluk        (aluk),
    .alu_out     (alu_out),
    .gate_alu    (gate_alu),
    .ld_reg      (ld_reg),
    .dr_sel      (dr_sel),
    .wb_data     (wb_data),
    .ld_cc       (ld_cc),
    .nzp         (nzp),
    .done        (done),
    .illegal     (illegal)
  );

  always @(posedge clk) begin
    rf_sr1_data <= regs[sr1_sel];
    rf_sr2_data <= regs[sr2_sel];
    if (preload_en) begin
      for (int i = 0; i < 8; i++) regs[i] <= preload_vals[i];
    end else if (ld_reg) begin
      regs[dr_sel] <= wb_data;
    end
  end

  always_comb begin
    case (aluk)
      2'd0:    alu_out = alu_a + alu_b;
      2'd1:    alu_out = alu_a & alu_b;
      2'd2:    alu_out = ~alu_a;
      default: alu_out = alu_a;
    endcase
  end

  // ---------------- reference model helpers ----------------
  function automatic logic [2:0] cc_of(input logic [15:0] v);
    if ($signed(v) < 0) return 3'b100;
    if (v == 16'd0)     return 3'b010;
    return 3'b001;
  endfunction

  function automatic logic [15:0] sext5(input logic [4:0] imm);
    int s;
    s = (imm >= 5'd16) ? int'(imm) - 32 : int'(imm);
    return 16'(s);
  endfunction

  // Load the register file and the model with the same contents (DUT idle).
  task automatic preload(input logic [15:0] vals [8]);
    for (int i = 0; i < 8; i++) begin
      preload_vals[i] = vals[i];
      ref_regs[i]     = vals[i];
    end
    preload_en = 1'b1;
    @(posedge clk); #1 preload_en = 1'b0;
    @(negedge clk);
  endtask

  // Issue one instruction from an idle DUT and check it cycle by cycle.
  // Called between edges; returns mid-cycle with the DUT idle again.
  task automatic run_op(input logic [15:0] ins, output logic [15:0] obs_wb);
    logic [3:0]  op;
    logic        legal;
    logic [15:0] a, b, res;
    logic [1:0]  exp_k;
    op    = ins[15:12];
    legal = (op == 4'd1) || (op == 4'd5) || (op == 4'd9);
    a     = ref_regs[ins[8:6]];
    b     = ins[5] ? sext5(ins[4:0]) : ref_regs[ins[2:0]];
    case (op)
      4'd1:    begin res = a + b; exp_k = 2'd0; end
      4'd5:    begin res = a & b; exp_k = 2'd1; end
      default: begin res = ~a;    exp_k = 2'd2; end
    endcase
    obs_wb = 'x;

    instr = ins; instr_valid = 1'b1;
    @(posedge clk); #1 instr_valid = 1'b0; instr = 16'($urandom);

    @(negedge clk); // cycle 1: DECODE
    vectors++;
    if ({instr_ready, sr1_sel, sr2_sel, dr_sel} !== {1'b0, ins[8:6], ins[2:0], ins[11:9]}) begin
      miscompares++;
      $display("FAIL decode_sel ins=%h: got rdy=%b sr1=%0d sr2=%0d dr=%0d want rdy=0 sr1=%0d sr2=%0d dr=%0d",
               ins, instr_ready, sr1_sel, sr2_sel, dr_sel, ins[8:6], ins[2:0], ins[11:9]);
    end
    vectors++;
    if ({illegal, ld_reg, ld_cc, done} !== {!legal, 3'b000}) begin
      miscompares++;
      $display("FAIL decode_strobes ins=%h: got ill/ldr/ldcc/done=%b want %b", ins,
               {illegal, ld_reg, ld_cc, done}, {!legal, 3'b000});
    end

    if (!legal) begin
      @(negedge clk); // back in IDLE
      vectors++;
      if ({instr_ready, illegal, ld_reg, ld_cc, done, nzp} !== {5'b10000, ref_nzp}) begin
        miscompares++;
        $display("FAIL illegal_return ins=%h: got rdy/ill/ldr/ldcc/done=%b nzp=%b want 10000 nzp=%b",
                 ins, {instr_ready, illegal, ld_reg, ld_cc, done}, nzp, ref_nzp);
      end
      return;
    end

    @(negedge clk); // cycle 2: READ
    vectors++;
    if ({gate_alu, ld_reg, done} !== 3'b000) begin
      miscompares++;
      $display("FAIL read_strobes ins=%h: got gate/ldr/done=%b want 000", ins, {gate_alu, ld_reg, done});
    end

    @(negedge clk); // cycle 3: EXEC
    vectors++;
    if ({gate_alu, ld_reg, done, alu_a, aluk} !== {3'b100, a, exp_k}) begin
      miscompares++;
      $display("FAIL exec_ops ins=%h: got gate/ldr/done=%b a=%h k=%0d want 100 a=%h k=%0d",
               ins, {gate_alu, ld_reg, done}, alu_a, aluk, a, exp_k);
    end
    if (op != 4'd9) begin
      vectors++;
      if (alu_b !== b) begin
        miscompares++;
        $display("FAIL exec_alu_b ins=%h: got %h want %h", ins, alu_b, b);
      end
    end

    @(negedge clk); // cycle 4: WB
    obs_wb = wb_data;
    vectors++;
    if ({gate_alu, ld_reg, ld_cc, done, wb_data, dr_sel, nzp} !== {4'b0111, res, ins[11:9], ref_nzp}) begin
      miscompares++;
      $display("FAIL wb ins=%h: got gate/ldr/ldcc/done=%b wb=%h dr=%0d nzp=%b want 0111 wb=%h dr=%0d nzp=%b",
               ins, {gate_alu, ld_reg, ld_cc, done}, wb_data, dr_sel, nzp, res, ins[11:9], ref_nzp);
    end
    ref_regs[ins[11:9]] = res;
    ref_nzp             = cc_of(res);

    @(negedge clk); // cycle 5: IDLE
    vectors++;
    if ({instr_ready, ld_reg, ld_cc, done, nzp} !== {4'b1000, ref_nzp}) begin
      miscompares++;
      $display("FAIL retire ins=%h: got rdy/ldr/ldcc/done=%b nzp=%b want 1000 nzp=%b",
               ins, {instr_ready, ld_reg, ld_cc, done}, nzp, ref_nzp);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    ref_nzp = 3'b010;
    @(negedge clk);
    vectors++;
    if ({instr_ready, nzp, gate_alu, ld_reg, ld_cc, done, illegal} !== {1'b1, 3'b010, 5'b00000}) begin
      miscompares++;
      $display("FAIL reset_state: got rdy=%b nzp=%b gate/ldr/ldcc/done/ill=%b want rdy=1 nzp=010 00000",
               instr_ready, nzp, {gate_alu, ld_reg, ld_cc, done, illegal});
    end
    vectors++;
    if ({alu_a, alu_b, aluk, wb_data, sr1_sel, sr2_sel, dr_sel} !== '0) begin
      miscompares++;
      $display("FAIL reset_regs: got a=%h b=%h k=%0d wb=%h sr1=%0d sr2=%0d dr=%0d want all 0",
               alu_a, alu_b, aluk, wb_data, sr1_sel, sr2_sel, dr_sel);
    end
  endtask

  task automatic test_directed();
    logic [15:0] v [8];
    logic [15:0] w;
    for (int i = 0; i < 8; i++) v[i] = 16'h0;
    v[2] = 16'd1234; v[3] = 16'd2345;
    preload(v);
    run_op(16'h1283, w);                     // ADD R1,R2,R3
    vectors++;
    if (w !== 16'd3579 || nzp !== 3'b001) begin
      miscompares++;
      $display("FAIL add_reg: got wb=%0d nzp=%b want 3579 nzp=001", w, nzp);
    end

    v[1] = 16'h1234;
    preload(v);
    run_op(16'h5070, w);                     // AND R0,R1,#-16
    vectors++;
    if (w !== 16'h1230 || nzp !== 3'b001) begin
      miscompares++;
      $display("FAIL and_imm: got wb=%h nzp=%b want 1230 nzp=001", w, nzp);
    end

    v[5] = 16'h1234;
    preload(v);
    run_op(16'h997F, w);                     // NOT R4,R5
    vectors++;
    if (w !== 16'hEDCB || nzp !== 3'b100) begin
      miscompares++;
      $display("FAIL not_op: got wb=%h nzp=%b want EDCB nzp=100", w, nzp);
    end

    v[6] = 16'd5;
    preload(v);
    run_op(16'h1DBB, w);                     // ADD R6,R6,#-5 (wraps to 0)
    vectors++;
    if (w !== 16'h0000 || nzp !== 3'b010) begin
      miscompares++;
      $display("FAIL add_zero: got wb=%h nzp=%b want 0000 nzp=010", w, nzp);
    end

    run_op(16'h0E02, w);                     // BR: rejected
  endtask

  task automatic test_back_to_back();
    logic [15:0] v [8];
    int          done_cyc [$];
    logic [15:0] done_wb [$];
    for (int i = 0; i < 8; i++) v[i] = 16'h0;
    v[2] = 16'd1234; v[3] = 16'd2345; v[6] = 16'd5;
    preload(v);
    instr = 16'h1283; instr_valid = 1'b1;
    @(posedge clk); #1 instr = 16'h1DBB;      // cycle 1; valid held while busy
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        done_cyc.push_back(c);
        done_wb.push_back(wb_data);
      end
      vectors++;
      if (instr_ready !== ((c == 5) || (c >= 10))) begin
        miscompares++;
        $display("FAIL b2b_ready cycle %0d: got %b want %b", c, instr_ready, (c == 5) || (c >= 10));
      end
      @(posedge clk); #1 if (c == 5) instr_valid = 1'b0;
    end
    vectors++;
    if (done_cyc.size() != 2 || done_cyc[0] != 4 || done_cyc[1] != 9) begin
      miscompares++;
      $display("FAIL b2b_done_timing: got %0d pulses first=%0d second=%0d want 2 pulses at 4 and 9",
               done_cyc.size(), (done_cyc.size() > 0) ? done_cyc[0] : -1,
               (done_cyc.size() > 1) ? done_cyc[1] : -1);
    end else begin
      vectors++;
      if (done_wb[0] !== 16'd3579 || done_wb[1] !== 16'h0000 || nzp !== 3'b010) begin
        miscompares++;
        $display("FAIL b2b_results: got wb0=%0d wb1=%h nzp=%b want 3579 0000 010", done_wb[0], done_wb[1], nzp);
      end
    end
    ref_regs[1] = 16'd3579; ref_regs[6] = 16'h0000; ref_nzp = 3'b010;
  endtask

  task automatic test_reset_in_exec();
    logic [15:0] v [8];
    logic [15:0] w;
    for (int i = 0; i < 8; i++) v[i] = 16'h0;
    v[2] = 16'd1234; v[3] = 16'd2345;
    preload(v);
    run_op(16'h1283, w);                     // leaves nzp=001
    instr = 16'h1283; instr_valid = 1'b1;
    @(posedge clk); #1 instr_valid = 1'b0;
    repeat (3) @(negedge clk);               // now in EXEC
    vectors++;
    if (gate_alu !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_exec_reached: got gate_alu=%b want 1", gate_alu);
    end
    rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    ref_nzp = 3'b010;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      vectors++;
      if ({ld_reg, ld_cc, done, instr_ready, nzp} !== {4'b0001, 3'b010}) begin
        miscompares++;
        $display("FAIL rst_exec_abort cycle %0d: got ldr/ldcc/done/rdy=%b nzp=%b want 0001 nzp=010",
                 c, {ld_reg, ld_cc, done, instr_ready}, nzp);
      end
    end
  endtask

  task automatic test_random();
    logic [15:0] v [8];
    logic [15:0] ins, w;
    logic [3:0]  op;
    for (int n = 0; n < 60; n++) begin
      if (n % 12 == 0) begin
        for (int i = 0; i < 8; i++) v[i] = 16'($urandom);
        if (n == 24) v[3] = 16'h8000;        // sign-boundary operand
        preload(v);
      end
      case ($urandom_range(0, 9))
        0:       begin
                   op = 4'($urandom);
                   while (op == 4'd1 || op == 4'd5 || op == 4'd9) op = 4'($urandom);
                 end
        1, 2, 3: op = 4'd1;
        4, 5, 6: op = 4'd5;
        default: op = 4'd9;
      endcase
      ins = {op, 12'($urandom)};
      run_op(ins, w);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    ref_nzp = 3'b010;
    for (int i = 0; i < 8; i++) begin
      preload_vals[i] = '0;
      ref_regs[i]     = '0;
    end
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_in_exec();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
